// File: rtl/timeslice_rr_arbiter.sv
// Four-way round-robin arbiter with per-grant time slices, early release and a dead handover cycle.
// Latency: one edge from req to grant. Backpressure: none; holders lose the grant on timeout, req drop or rel.
module timeslice_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    input  logic [2:0] slice_len,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [2:0] slice_cnt,
    output logic       expire
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [2:0] slice_lim, slice_lim_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] grant_id_nxt;
    logic [2:0] slice_cnt_nxt;
    logic       expire_nxt;

    logic [1:0] base;
    logic [7:0] req_dbl;
    logic [7:0] req_sh;
    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] win_id;
    logic       win_vld;
    logic       hold_req;
    logic       hold_rel;

    // Rotate req so the requester after ptr sits at bit 0, then take the lowest set bit.
    assign base    = ptr + 2'd1;
    assign req_dbl = {req, req};
    assign req_sh  = req_dbl >> base;
    assign req_rot = req_sh[3:0];
    assign win_vld = |req;
    assign win_id  = base + win_off;

    always_comb begin
        win_off = 2'd3;
        if (req_rot[0])      win_off = 2'd0;
        else if (req_rot[1]) win_off = 2'd1;
        else if (req_rot[2]) win_off = 2'd2;
    end

    assign hold_req = req[grant_id];
    assign hold_rel = rel[grant_id];
    assign busy     = (state == GRANT);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        slice_lim_nxt = slice_lim;
        grant_nxt     = 4'd0;
        grant_id_nxt  = 2'd0;
        slice_cnt_nxt = 3'd0;
        expire_nxt    = 1'b0;
        case (state)
            GRANT: begin
                // Early exit wins over a coincident timeout, so it suppresses expire.
                if (!hold_req || hold_rel) begin
                    state_nxt = HANDOVER;
                end else if (slice_cnt == slice_lim) begin
                    state_nxt  = HANDOVER;
                    expire_nxt = 1'b1;
                end else begin
                    grant_nxt     = grant;
                    grant_id_nxt  = grant_id;
                    slice_cnt_nxt = slice_cnt + 3'd1;
                end
            end
            default: begin
                if (win_vld) begin
                    state_nxt     = GRANT;
                    grant_nxt     = 4'd1 << win_id;
                    grant_id_nxt  = win_id;
                    ptr_nxt       = win_id;
                    slice_lim_nxt = slice_len;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            slice_lim <= 3'd0;
            grant     <= 4'd0;
            grant_id  <= 2'd0;
            slice_cnt <= 3'd0;
            expire    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            slice_lim <= slice_lim_nxt;
            grant     <= grant_nxt;
            grant_id  <= grant_id_nxt;
            slice_cnt <= slice_cnt_nxt;
            expire    <= expire_nxt;
        end
    end

endmodule

// File: doc/timeslice_rr_arbiter.md
TIMESLICE_RR_ARBITER -- requirements
Module: timeslice_rr_arbiter

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 4 and slice counter width at 3 bits.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester access request, level, bit i = requester i.
REQ-005 rel  input  4  per-requester early release, level, honoured only for the current holder.
REQ-006 slice_len  input  3  slice length minus one, sampled on the edge that issues a grant.
REQ-007 grant  output  4  one-hot grant, registered; all-zero when no holder.
REQ-008 grant_id  output  2  index of the current holder, registered; 0 when grant is all-zero.
REQ-009 busy  output  1  high while state is GRANT.
REQ-010 slice_cnt  output  3  cycles elapsed in the current slice, registered.
REQ-011 expire  output  1  one-cycle registered pulse marking a slice ended by timeout.

Function
REQ-012 The FSM SHALL have exactly 3 states: IDLE, GRANT and HANDOVER.
REQ-013 IDLE: grant=0, busy=0, slice_cnt=0; if any req bit is high, the next edge SHALL enter GRANT with the winner's grant bit set.
REQ-014 Arbitration latency SHALL be 1 cycle: req sampled high at edge k gives grant visible after edge k.
REQ-015 The winner SHALL be the first requester with req high, scanning from (ptr+1) mod 4 upward with wrap; ptr holds the index of the last granted requester.
REQ-016 ptr SHALL update to the winner's index on the edge that issues the grant.
REQ-017 On entry to GRANT, slice_len SHALL be latched into an internal slice_lim register; later changes to slice_len SHALL NOT affect the active slice.
REQ-018 GRANT: slice_cnt SHALL start at 0 and increment by 1 each cycle the holder keeps req high and rel low.
REQ-019 slice_cnt SHALL never wrap; its maximum value is 7, reached only when slice_lim=7.
REQ-020 GRANT, timeout: when slice_cnt == slice_lim, holder req=1 and holder rel=0, the next edge SHALL enter HANDOVER and set expire=1 for exactly one cycle.
REQ-021 GRANT, early exit: when holder req=0 or holder rel=1, the next edge SHALL enter HANDOVER with expire=0; early exit SHALL take priority over a coincident timeout.
REQ-022 slice_lim=0 SHALL yield a grant lasting exactly 1 cycle.
REQ-023 rel and req bits of non-holders SHALL NOT affect the current slice.
REQ-024 HANDOVER SHALL last exactly 1 cycle with grant=0, busy=0 and slice_cnt=0 (dead cycle between holders).
REQ-025 HANDOVER SHALL arbitrate exactly as IDLE (REQ-015): any req high -> GRANT, else -> IDLE.
REQ-026 After a timeout, the expired holder SHALL be granted again only if no other requester has req high (fairness via ptr).
REQ-027 grant SHALL always be one-hot or zero, and grant_id SHALL always match grant.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, grant=0, grant_id=0, busy=0, slice_cnt=0, expire=0, slice_lim=0 and ptr=3, so requester 0 has first priority.
REQ-029 Reset asserted mid-slice SHALL abort the slice with no expire pulse; arbitration SHALL resume on the first edge after reset deasserts.

Verification
REQ-030 Reset then req=4'b1111 with slice_len=2 -> grants 0,1,2,3,0 in order, each 3 cycles long, separated by 1-cycle HANDOVER, with expire pulsing after each slice.
REQ-031 req=4'b0100 only with slice_len=0 -> grant=4'b0100 for 1 cycle, then HANDOVER, then grant again, repeating with a period of 2 cycles.
REQ-032 Holder 1 with slice_len=7 raises rel[1] when slice_cnt=3 -> HANDOVER on the next edge with expire=0 and slice_cnt=0.
REQ-033 Holder 2 is at slice_cnt==slice_lim and asserts rel[2] in the same cycle -> expire stays 0 and the block enters HANDOVER.
REQ-034 slice_len changes from 5 to 1 mid-slice -> the current slice still runs 6 cycles, and the next grant uses 1 (2 cycles).
REQ-035 reset pulsed while grant=4'b1000 and slice_cnt=4 -> all outputs go to 0 asynchronously; with req=4'b1001 held, the first grant after release goes to requester 0.
